// File: rtl/wallace_mul_ctrl.sv
// rtl/wallace_mul_ctrl.sv - sequencer for a Wallace-tree multiplier with external reduction layer
// Optional MUL_RESULT_REUSE_EN keeps the last full product to answer repeated operands early.
module wallace_mul_ctrl #(
  parameter int WIDTH = 32,
  parameter int ROWS  = WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [WIDTH-1:0]        req_a,
  input  logic [WIDTH-1:0]        req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [WIDTH-1:0]        resp_data,
  output logic [ROWS*2*WIDTH-1:0] red_p_o,
  output logic [7:0]              red_lines_o,
  input  logic [ROWS*2*WIDTH-1:0] red_p_i,
  input  logic [7:0]              red_lines_i
);

  localparam int PW = 2 * WIDTH;
  localparam logic [7:0] ROWS_L = 8'(ROWS);

  typedef enum logic [2:0] {IDLE, PPGEN, REDUCE, FINAL, DONE} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   mag_a_q;
  logic [WIDTH-1:0]   mag_b_q;
  logic               neg_q;
  logic [ROWS*PW-1:0] rows_q;
  logic [7:0]         lines_q;

  logic               a_signed, b_signed, accept, hit;
  logic [WIDTH-1:0]   abs_a, abs_b, hit_data, final_data;
  logic [PW-1:0]      prod_sum, prod;
  logic [ROWS*PW-1:0] pp;

  function automatic logic [WIDTH-1:0] pick_half(input logic [1:0] op, input logic [PW-1:0] p);
    return (op == 2'b00) ? p[WIDTH-1:0] : p[PW-1:WIDTH];
  endfunction

  // MUL shares the signed/signed class with MULH; MULHSU signs only a; MULHU signs neither.
  assign a_signed = (req_op != 2'b11);
  assign b_signed = ~req_op[1];
  assign abs_a    = (a_signed && req_a[WIDTH-1]) ? -req_a : req_a;
  assign abs_b    = (b_signed && req_b[WIDTH-1]) ? -req_b : req_b;

  assign req_ready  = rst_n && !flush && (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == DONE);

  assign red_p_o     = (state == REDUCE) ? rows_q  : '0;
  assign red_lines_o = (state == REDUCE) ? lines_q : 8'd0;

  always_comb begin
    pp = '0;
    for (int i = 0; i < ROWS && i < WIDTH; i++) begin
      if (mag_b_q[i]) pp[i*PW +: PW] = {{WIDTH{1'b0}}, mag_a_q} << i;
    end
  end

  assign prod_sum   = rows_q[0 +: PW] + rows_q[PW +: PW];
  assign prod       = neg_q ? -prod_sum : prod_sum;
  assign final_data = pick_half(op_q, prod);

`ifdef MUL_RESULT_REUSE_EN
  logic             cache_valid;
  logic [PW-1:0]    cache_prod;
  logic [WIDTH-1:0] cache_a, cache_b, raw_a_q, raw_b_q;
  logic [1:0]       cache_cls;

  assign hit = cache_valid && (cache_a == req_a) && (cache_b == req_b) &&
               (cache_cls == {a_signed, b_signed});
  assign hit_data = pick_half(req_op, cache_prod);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cache_valid <= 1'b0;
      cache_prod  <= '0;
      cache_a     <= '0;
      cache_b     <= '0;
      cache_cls   <= 2'b00;
      raw_a_q     <= '0;
      raw_b_q     <= '0;
    end else begin
      if (accept) begin
        raw_a_q <= req_a;
        raw_b_q <= req_b;
      end
      if (state == FINAL) begin
        cache_valid <= 1'b1;
        cache_prod  <= prod;
        cache_a     <= raw_a_q;
        cache_b     <= raw_b_q;
        cache_cls   <= {op_q != 2'b11, ~op_q[1]};
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      rows_q    <= '0;
      lines_q   <= 8'd0;
      resp_data <= '0;
    end else if (flush) begin
      state   <= IDLE;
      lines_q <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= req_op;
            mag_a_q <= abs_a;
            mag_b_q <= abs_b;
            neg_q   <= (a_signed & req_a[WIDTH-1]) ^ (b_signed & req_b[WIDTH-1]);
            if (hit) begin
              resp_data <= hit_data;
              state     <= DONE;
            end else begin
              state <= PPGEN;
            end
          end
        end
        PPGEN: begin
          rows_q  <= pp;
          lines_q <= ROWS_L;
          state   <= REDUCE;
        end
        // One reduction layer per cycle until only the final two rows remain.
        REDUCE: begin
          rows_q  <= red_p_i;
          lines_q <= red_lines_i;
          if (red_lines_i <= 8'd2) state <= FINAL;
        end
        FINAL: begin
          resp_data <= final_data;
          state     <= DONE;
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wallace_mul_ctrl.md
WALLACE_MUL_CTRL -- requirements
Module: wallace_mul_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter ROWS, default WIDTH, partial-product row count.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  input  1  abort the current operation.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  controller can accept a request.
REQ-008 SHALL have port req_op  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-009 SHALL have port req_a  input  WIDTH  rs1 operand.
REQ-010 SHALL have port req_b  input  WIDTH  rs2 operand.
REQ-011 SHALL have port resp_valid  output  1  result present.
REQ-012 SHALL have port resp_ready  input  1  consumer takes the result.
REQ-013 SHALL have port resp_data  output  WIDTH  selected result half.
REQ-014 SHALL have port red_p_o  output  ROWS x 2*WIDTH  rows driven to the external reduction-layer datapath.
REQ-015 SHALL have port red_lines_o  output  8  valid row count driven to the datapath.
REQ-016 SHALL have port red_p_i  input  ROWS x 2*WIDTH  reduced rows returned combinationally by the datapath.
REQ-017 SHALL have port red_lines_i  input  8  row count returned by the datapath.

Function
REQ-018 SHALL implement FSM states IDLE, PPGEN, REDUCE, FINAL, DONE.
REQ-019 SHALL assert req_ready only in IDLE with flush low; acceptance is req_valid && req_ready.
REQ-020 On acceptance SHALL register op, |a| and |b| (magnitude of an operand only if that operand is signed for the op; for MULHSU only a is signed) plus neg = sign(a) XOR sign(b) over the signed operands; IDLE->PPGEN.
REQ-021 In PPGEN SHALL load row i = (|b| bit i ? |a| << i : 0) and lines = ROWS; PPGEN->REDUCE.
REQ-022 In REDUCE SHALL drive the row register and lines onto red_p_o and red_lines_o, and each cycle SHALL capture red_p_i and red_lines_i; SHALL go to FINAL when the captured count is <= 2.
REQ-023 For WIDTH=32 the row count sequence SHALL be 32,22,15,10,7,5,4,3,2: exactly 8 REDUCE cycles.
REQ-024 In FINAL SHALL form prod = row0 + row1 modulo 2^(2*WIDTH), negate it if neg, select low half for MUL and high half otherwise, register the result into resp_data; FINAL->DONE.
REQ-025 resp_valid SHALL be high only in DONE; DONE->IDLE on resp_ready; resp_data SHALL hold stable while resp_valid && !resp_ready.
REQ-026 Request-to-result latency SHALL be 10 edges: resp_valid rises after the 10th rising edge following the accepting edge.
REQ-027 flush SHALL force IDLE on the next edge from any state, drop the operation (no response), and win over a simultaneous req_valid.
REQ-028 red_p_o and red_lines_o SHALL be zero outside REDUCE.
REQ-029 Back-to-back: a request SHALL be acceptable in the cycle after the DONE->IDLE transition.

Reset
REQ-030 When rst_n is low at a rising edge, the FSM SHALL enter IDLE and req_ready, resp_valid, resp_data, red_lines_o, all row registers and any cached state SHALL clear to 0.
REQ-031 Reset mid-operation SHALL drop the operation with no response; req_ready SHALL be 1 in the first cycle after rst_n returns high.

Configuration
REQ-032 With MUL_RESULT_REUSE_EN defined, the block SHALL keep the last full 2*WIDTH product plus its req_a, req_b and signedness class; an accepted request matching all of these SHALL go IDLE->DONE, with resp_valid after 1 edge.
REQ-033 With MUL_RESULT_REUSE_EN defined, flush and reset SHALL invalidate the cache.
REQ-034 Without MUL_RESULT_REUSE_EN, no cache SHALL exist and every request SHALL take the full 10-edge latency.

Verification
REQ-035 MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> resp_data=0xFFFFFFFE after 10 edges; MUL of the same -> 0x00000001.
REQ-036 MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF(-1), b=0x00000002 -> 0xFFFFFFFF.
REQ-037 Check red_lines_o over a run: 32,22,15,10,7,5,4,3; resp_ready held low 5 cycles -> resp_data stable, resp_valid stays high.
REQ-038 flush in cycle 4 of REDUCE -> no resp_valid, req_ready=1 next cycle; flush with req_valid in IDLE -> request not accepted.
REQ-039 rst_n low during FINAL -> all outputs 0, next request completes correctly.
REQ-040 With MUL_RESULT_REUSE_EN: MULH 7x-3 (0xFFFFFFFF) then MUL 7x-3 -> second resp_data=0xFFFFFFEB after 1 edge; MULHU of the same operands -> full 10 edges.
